// File: rtl/maze_path_checker_if.sv
// Move-stream, maze-memory read port and status signals of the path checker.
// slave is the checker side; master is the solver/memory/observer side.
interface maze_path_checker_if #(
  parameter int ADDR_W = 4,
  parameter int ADDR_H = 4,
  parameter int STEP_W = 8
);
  logic              start;
  logic              move_valid;
  logic [1:0]        move;
  logic              move_ready;
  logic              path_end;
  logic              mem_rd;
  logic [ADDR_W-1:0] addr_x;
  logic [ADDR_H-1:0] addr_y;
  logic              mem_data;
  logic              busy;
  logic              path_ok;
  logic              path_bad;
  logic [1:0]        err_code;
  logic [ADDR_W-1:0] pos_x;
  logic [ADDR_H-1:0] pos_y;
  logic [STEP_W-1:0] step_count;

  modport slave (
    input  start, move_valid, move, path_end, mem_data,
    output move_ready, mem_rd, addr_x, addr_y, busy, path_ok, path_bad,
           err_code, pos_x, pos_y, step_count
  );

  modport master (
    output start, move_valid, move, path_end, mem_data,
    input  move_ready, mem_rd, addr_x, addr_y, busy, path_ok, path_bad,
           err_code, pos_x, pos_y, step_count
  );
endinterface

// File: rtl/maze_path_checker.sv
// Replays the solver's move stream from (0,0), reading the maze at each new
// cell, and reports whether the path stays legal and ends on the goal cell.
module maze_path_checker #(
  parameter int ADDR_W = 4,
  parameter int ADDR_H = 4,
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int STEP_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  maze_path_checker_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WAIT, READ, EVAL, PASS, FAIL} state_t;

  localparam logic signed [ADDR_W:0] X_MAX  = (ADDR_W+1)'(WIDTH - 1);
  localparam logic signed [ADDR_H:0] Y_MAX  = (ADDR_H+1)'(HEIGHT - 1);
  localparam logic signed [ADDR_W:0] ONE_X  = (ADDR_W+1)'(1);
  localparam logic signed [ADDR_H:0] ONE_Y  = (ADDR_H+1)'(1);
  localparam logic [ADDR_W-1:0]      GOAL_X = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_H-1:0]      GOAL_Y = ADDR_H'(HEIGHT - 1);
  localparam logic [STEP_W-1:0]      STEP_MAX = '1;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OOB  = 2'b01;
  localparam logic [1:0] ERR_WALL = 2'b10;
  localparam logic [1:0] ERR_END  = 2'b11;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pos_x_reg, pos_x_next;
  logic [ADDR_H-1:0] pos_y_reg, pos_y_next;
  logic [ADDR_W-1:0] cand_x_reg, cand_x_next;
  logic [ADDR_H-1:0] cand_y_reg, cand_y_next;
  logic [STEP_W-1:0] step_reg, step_next;
  logic [1:0]        err_reg, err_next;

  logic signed [ADDR_W:0] cand_x;
  logic signed [ADDR_H:0] cand_y;
  logic                   oob;
  logic                   at_goal;

  // One extra signed bit lets a step off either edge show up as <0 or >MAX.
  always_comb begin
    cand_x = $signed({1'b0, pos_x_reg});
    cand_y = $signed({1'b0, pos_y_reg});
    case (bus.move)
      2'b00:   cand_y = $signed({1'b0, pos_y_reg}) - ONE_Y;
      2'b01:   cand_x = $signed({1'b0, pos_x_reg}) + ONE_X;
      2'b10:   cand_y = $signed({1'b0, pos_y_reg}) + ONE_Y;
      default: cand_x = $signed({1'b0, pos_x_reg}) - ONE_X;
    endcase
    oob = cand_x[ADDR_W] || (cand_x > X_MAX) || cand_y[ADDR_H] || (cand_y > Y_MAX);
  end

  assign at_goal = (pos_x_reg == GOAL_X) && (pos_y_reg == GOAL_Y);

  always_comb begin
    state_next  = state_reg;
    pos_x_next  = pos_x_reg;
    pos_y_next  = pos_y_reg;
    cand_x_next = cand_x_reg;
    cand_y_next = cand_y_reg;
    step_next   = step_reg;
    err_next    = err_reg;
    if (bus.start) begin
      state_next = WAIT;
      pos_x_next = '0;
      pos_y_next = '0;
      step_next  = '0;
      err_next   = ERR_NONE;
    end else begin
      case (state_reg)
        WAIT: begin
          // A move wins over a simultaneous path_end.
          if (bus.move_valid) begin
            if (oob) begin
              state_next = FAIL;
              err_next   = ERR_OOB;
            end else begin
              cand_x_next = cand_x[ADDR_W-1:0];
              cand_y_next = cand_y[ADDR_H-1:0];
              state_next  = READ;
            end
          end else if (bus.path_end) begin
            if (at_goal) begin
              state_next = PASS;
            end else begin
              state_next = FAIL;
              err_next   = ERR_END;
            end
          end
        end
        READ: state_next = EVAL;
        EVAL: begin
          if (bus.mem_data) begin
            state_next = FAIL;
            err_next   = ERR_WALL;
          end else begin
            pos_x_next = cand_x_reg;
            pos_y_next = cand_y_reg;
            if (step_reg != STEP_MAX) step_next = step_reg + 1'b1;
            state_next = WAIT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      pos_x_reg  <= '0;
      pos_y_reg  <= '0;
      cand_x_reg <= '0;
      cand_y_reg <= '0;
      step_reg   <= '0;
      err_reg    <= ERR_NONE;
    end else begin
      state_reg  <= state_next;
      pos_x_reg  <= pos_x_next;
      pos_y_reg  <= pos_y_next;
      cand_x_reg <= cand_x_next;
      cand_y_reg <= cand_y_next;
      step_reg   <= step_next;
      err_reg    <= err_next;
    end
  end

  assign bus.move_ready = (state_reg == WAIT);
  assign bus.mem_rd     = (state_reg == READ);
  assign bus.busy       = (state_reg == WAIT) || (state_reg == READ) || (state_reg == EVAL);
  assign bus.path_ok    = (state_reg == PASS);
  assign bus.path_bad   = (state_reg == FAIL);
  assign bus.err_code   = err_reg;
  assign bus.addr_x     = (state_reg == READ || state_reg == EVAL) ? cand_x_reg : pos_x_reg;
  assign bus.addr_y     = (state_reg == READ || state_reg == EVAL) ? cand_y_reg : pos_y_reg;
  assign bus.pos_x      = pos_x_reg;
  assign bus.pos_y      = pos_y_reg;
  assign bus.step_count = step_reg;

endmodule

// File: tb/tb_maze_path_checker.sv
// Self-checking bench for maze_path_checker: directed scenarios plus random
// mazes and walks scored against a grid-walking reference model.
module tb_maze_path_checker;
  localparam int W = 16;
  localparam int H = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   rd_cnt = 0;
  bit   maze [0:H-1][0:W-1];

  maze_path_checker_if #(.ADDR_W(4), .ADDR_H(4), .STEP_W(8)) bus ();

  maze_path_checker #(.ADDR_W(4), .ADDR_H(4), .WIDTH(W), .HEIGHT(H), .STEP_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Maze memory: one-cycle registered read.
  always @(posedge clk) begin
    bus.mem_data <= bus.mem_rd ? maze[bus.addr_y][bus.addr_x] : 1'b0;
    if (bus.mem_rd) rd_cnt <= rd_cnt + 1;
  end

  // Reference model: a plain grid walk.
  int mx, my, msteps, merr;
  bit mdone, mpass;

  task automatic model_reset();
    mx = 0; my = 0; msteps = 0; merr = 0; mdone = 0; mpass = 0;
  endtask

  task automatic model_move(input logic [1:0] d);
    int nx = mx;
    int ny = my;
    if (mdone) return;
    case (d)
      2'd0: ny = ny - 1;
      2'd1: nx = nx + 1;
      2'd2: ny = ny + 1;
      default: nx = nx - 1;
    endcase
    if (nx < 0 || nx >= W || ny < 0 || ny >= H) begin
      mdone = 1; merr = 1;
    end else if (maze[ny][nx]) begin
      mdone = 1; merr = 2;
    end else begin
      mx = nx; my = ny;
      if (msteps < 255) msteps++;
    end
  endtask

  task automatic model_end();
    if (mdone) return;
    mdone = 1;
    if (mx == W-1 && my == H-1) begin mpass = 1; merr = 0; end
    else merr = 3;
  endtask

  task automatic clear_maze();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) maze[y][x] = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  // Returns just after the handshake edge (or after the bound expires).
  task automatic send_move(input logic [1:0] d, output bit accepted);
    int n = 0;
    @(negedge clk);
    bus.move_valid = 1'b1; bus.move = d;
    while (!bus.move_ready && n < 8) begin @(negedge clk); n++; end
    accepted = bus.move_ready;
    @(posedge clk); #1;
    bus.move_valid = 1'b0;
  endtask

  // Wait until the checker is ready for a move or has stopped.
  task automatic wait_settle(output bit ok);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = bus.move_ready || !bus.busy;
    end
  endtask

  task automatic pulse_end();
    @(negedge clk); bus.path_end = 1'b1;
    @(posedge clk); #1; bus.path_end = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.move_ready, bus.mem_rd, bus.busy, bus.path_ok, bus.path_bad} !== 5'b0 ||
        bus.err_code !== 2'b00 || bus.pos_x !== 4'd0 || bus.pos_y !== 4'd0 ||
        bus.step_count !== 8'd0 || bus.addr_x !== 4'd0 || bus.addr_y !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: flags=%b err=%b pos=(%0d,%0d) steps=%0d, required all zero",
               {bus.move_ready, bus.mem_rd, bus.busy, bus.path_ok, bus.path_bad},
               bus.err_code, bus.pos_x, bus.pos_y, bus.step_count);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.move_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b ready=%b, required 0 0", bus.busy, bus.move_ready);
    end
  endtask

  task automatic test_open_path();
    bit acc;
    int rejected = 0;
    bit ok;
    clear_maze();
    do_start();
    for (int i = 0; i < 30; i++) begin
      send_move(i < 15 ? 2'b01 : 2'b10, acc);
      if (!acc) rejected++;
    end
    wait_settle(ok);
    pulse_end();
    checks++;
    if (rejected != 0 || !ok) begin
      errors++;
      $display("FAIL open_path_accept: rejected=%0d settled=%0d, required 0 1", rejected, ok);
    end
    checks++;
    if (bus.path_ok !== 1'b1 || bus.path_bad !== 1'b0 || bus.err_code !== 2'b00 ||
        bus.pos_x !== 4'd15 || bus.pos_y !== 4'd15 || bus.step_count !== 8'd30 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL open_path_result: ok=%b bad=%b err=%b pos=(%0d,%0d) steps=%0d, required 1 0 00 (15,15) 30",
               bus.path_ok, bus.path_bad, bus.err_code, bus.pos_x, bus.pos_y, bus.step_count);
    end
  endtask

  task automatic test_cadence();
    clear_maze();
    do_start();
    bus.move_valid = 1'b1; bus.move = 2'b01;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({bus.move_ready, bus.mem_rd} !== {k % 3 == 0, k % 3 == 1}) begin
        errors++;
        $display("FAIL cadence_T+%0d: ready,mem_rd=%b, required %b", k,
                 {bus.move_ready, bus.mem_rd}, {k % 3 == 0, k % 3 == 1});
      end
      if (k % 3 == 1) begin
        checks++;
        if (bus.addr_x !== 4'(k / 3 + 1) || bus.addr_y !== 4'd0) begin
          errors++;
          $display("FAIL cadence_addr_T+%0d: addr=(%0d,%0d), required (%0d,0)", k,
                   bus.addr_x, bus.addr_y, k / 3 + 1);
        end
      end
      @(negedge clk);
    end
    bus.move_valid = 1'b0;
  endtask

  task automatic test_oob();
    bit acc;
    int base;
    clear_maze();
    do_start();
    base = rd_cnt;
    send_move(2'b00, acc);
    @(posedge clk); #1;
    checks++;
    if (!acc || bus.path_bad !== 1'b1 || bus.path_ok !== 1'b0 || bus.err_code !== 2'b01 ||
        rd_cnt != base || bus.move_ready !== 1'b0) begin
      errors++;
      $display("FAIL oob_up: acc=%0d bad=%b ok=%b err=%b reads=%0d ready=%b, required 1 1 0 01 0 0",
               acc, bus.path_bad, bus.path_ok, bus.err_code, rd_cnt - base, bus.move_ready);
    end
  endtask

  task automatic test_wall();
    bit acc;
    clear_maze();
    maze[0][1] = 1'b1;
    do_start();
    send_move(2'b01, acc);
    checks++;
    if (!acc || bus.mem_rd !== 1'b1 || bus.addr_x !== 4'd1 || bus.addr_y !== 4'd0) begin
      errors++;
      $display("FAIL wall_read: acc=%0d mem_rd=%b addr=(%0d,%0d), required 1 1 (1,0)",
               acc, bus.mem_rd, bus.addr_x, bus.addr_y);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.path_bad !== 1'b1 || bus.err_code !== 2'b10 || bus.pos_x !== 4'd0 ||
        bus.pos_y !== 4'd0 || bus.step_count !== 8'd0) begin
      errors++;
      $display("FAIL wall_result: bad=%b err=%b pos=(%0d,%0d) steps=%0d, required 1 10 (0,0) 0",
               bus.path_bad, bus.err_code, bus.pos_x, bus.pos_y, bus.step_count);
    end
  endtask

  task automatic test_end_off_goal();
    bit acc1, acc2, ok;
    bit seen_ready = 0;
    clear_maze();
    do_start();
    send_move(2'b01, acc1);
    send_move(2'b10, acc2);
    wait_settle(ok);
    pulse_end();
    checks++;
    if (!(acc1 && acc2 && ok) || bus.path_bad !== 1'b1 || bus.path_ok !== 1'b0 ||
        bus.err_code !== 2'b11 || bus.pos_x !== 4'd1 || bus.pos_y !== 4'd1) begin
      errors++;
      $display("FAIL end_off_goal: bad=%b ok=%b err=%b pos=(%0d,%0d), required 1 0 11 (1,1)",
               bus.path_bad, bus.path_ok, bus.err_code, bus.pos_x, bus.pos_y);
    end
    @(negedge clk); bus.move_valid = 1'b1; bus.move = 2'b01; bus.path_end = 1'b1;
    repeat (4) begin @(negedge clk); if (bus.move_ready) seen_ready = 1; end
    bus.move_valid = 1'b0; bus.path_end = 1'b0;
    checks++;
    if (seen_ready || bus.path_bad !== 1'b1 || bus.err_code !== 2'b11 || bus.pos_x !== 4'd1) begin
      errors++;
      $display("FAIL fail_hold: ready_seen=%0d bad=%b err=%b pos_x=%0d, required 0 1 11 1",
               seen_ready, bus.path_bad, bus.err_code, bus.pos_x);
    end
  endtask

  task automatic test_move_with_end();
    bit ok;
    clear_maze();
    do_start();
    bus.move_valid = 1'b1; bus.move = 2'b01; bus.path_end = 1'b1;
    @(posedge clk); #1;
    bus.move_valid = 1'b0; bus.path_end = 1'b0;
    wait_settle(ok);
    checks++;
    if (!ok || bus.busy !== 1'b1 || bus.path_ok !== 1'b0 || bus.path_bad !== 1'b0 ||
        bus.pos_x !== 4'd1 || bus.pos_y !== 4'd0 || bus.step_count !== 8'd1) begin
      errors++;
      $display("FAIL move_with_end: busy=%b ok=%b bad=%b pos=(%0d,%0d) steps=%0d, required 1 0 0 (1,0) 1",
               bus.busy, bus.path_ok, bus.path_bad, bus.pos_x, bus.pos_y, bus.step_count);
    end
  endtask

  task automatic test_abort();
    bit acc, acc1, acc2, ok;
    clear_maze();
    do_start();
    send_move(2'b01, acc);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.pos_x !== 4'd0 || bus.pos_y !== 4'd0 || bus.step_count !== 8'd0 ||
        bus.move_ready !== 1'b1 || bus.path_ok !== 1'b0 || bus.path_bad !== 1'b0 || bus.err_code !== 2'b00) begin
      errors++;
      $display("FAIL start_in_read: pos=(%0d,%0d) steps=%0d ready=%b ok=%b bad=%b err=%b, required (0,0) 0 1 0 0 00",
               bus.pos_x, bus.pos_y, bus.step_count, bus.move_ready, bus.path_ok, bus.path_bad, bus.err_code);
    end
    send_move(2'b01, acc1);
    send_move(2'b10, acc2);
    wait_settle(ok);
    pulse_end();
    checks++;
    if (!(acc1 && acc2 && ok) || bus.path_bad !== 1'b1 || bus.err_code !== 2'b11 ||
        bus.pos_x !== 4'd1 || bus.pos_y !== 4'd1 || bus.step_count !== 8'd2) begin
      errors++;
      $display("FAIL after_start_check: bad=%b err=%b pos=(%0d,%0d) steps=%0d, required 1 11 (1,1) 2",
               bus.path_bad, bus.err_code, bus.pos_x, bus.pos_y, bus.step_count);
    end
    do_start();
    send_move(2'b10, acc1);
    wait_settle(ok);
    send_move(2'b01, acc2);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.move_ready, bus.mem_rd, bus.busy, bus.path_ok, bus.path_bad} !== 5'b0 ||
        bus.pos_x !== 4'd0 || bus.pos_y !== 4'd0 || bus.step_count !== 8'd0 || bus.err_code !== 2'b00) begin
      errors++;
      $display("FAIL async_reset: flags=%b pos=(%0d,%0d) steps=%0d err=%b, required all zero",
               {bus.move_ready, bus.mem_rd, bus.busy, bus.path_ok, bus.path_bad},
               bus.pos_x, bus.pos_y, bus.step_count, bus.err_code);
    end
    @(negedge clk); rst = 1'b0;
    bus.move_valid = 1'b1; bus.move = 2'b10; bus.path_end = 1'b1;
    repeat (3) @(negedge clk);
    bus.move_valid = 1'b0; bus.path_end = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.move_ready !== 1'b0 || bus.pos_y !== 4'd0 ||
        bus.path_ok !== 1'b0 || bus.path_bad !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores: busy=%b ready=%b pos_y=%0d ok=%b bad=%b, required 0 0 0 0 0",
               bus.busy, bus.move_ready, bus.pos_y, bus.path_ok, bus.path_bad);
    end
  endtask

  task automatic test_saturation();
    bit acc, ok;
    int rejected = 0;
    clear_maze();
    do_start();
    for (int i = 0; i < 260; i++) begin
      send_move(i % 2 == 0 ? 2'b01 : 2'b11, acc);
      if (!acc) rejected++;
    end
    wait_settle(ok);
    checks++;
    if (rejected != 0 || !ok || bus.step_count !== 8'd255 || bus.pos_x !== 4'd0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL step_saturate: rejected=%0d steps=%0d pos_x=%0d busy=%b, required 0 255 0 1",
               rejected, bus.step_count, bus.pos_x, bus.busy);
    end
  endtask

  task automatic test_random();
    bit acc, ok;
    logic [1:0] d;
    int n, r;
    for (int t = 0; t < 24; t++) begin
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) maze[y][x] = ($urandom_range(0, 99) < 15);
      maze[0][0] = 1'b0;
      model_reset();
      do_start();
      n = $urandom_range(1, 40);
      for (int i = 0; i < n && !mdone; i++) begin
        r = $urandom_range(0, 9);
        d = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r < 9) ? 2'b00 : 2'b11;
        model_move(d);
        send_move(d, acc);
        checks++;
        if (!acc) begin
          errors++;
          $display("FAIL rand_%0d_accept_%0d: move not accepted, required accepted", t, i);
          break;
        end
      end
      wait_settle(ok);
      if (!mdone) begin
        model_end();
        pulse_end();
      end
      checks++;
      if (!ok || bus.path_ok !== mpass || bus.path_bad !== !mpass || bus.err_code !== 2'(merr) ||
          bus.pos_x !== 4'(mx) || bus.pos_y !== 4'(my) || bus.step_count !== 8'(msteps)) begin
        errors++;
        $display("FAIL rand_%0d_result: ok=%b bad=%b err=%0d pos=(%0d,%0d) steps=%0d, required %0d %0d %0d (%0d,%0d) %0d",
                 t, bus.path_ok, bus.path_bad, bus.err_code, bus.pos_x, bus.pos_y, bus.step_count,
                 mpass, !mpass, merr, mx, my, msteps);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.move_valid = 1'b0; bus.move = 2'b00; bus.path_end = 1'b0;
    clear_maze();
    test_reset();
    test_open_path();
    test_cadence();
    test_oob();
    test_wall();
    test_end_off_goal();
    test_move_with_end();
    test_abort();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/maze_path_checker.md
Name: maze_path_checker

Overview:
- Consumer end of the solver's Move stream: replays each 2-bit move from the start cell, reads the maze memory at every visited cell, and reports whether the path legally reaches the goal.
- Sits beside maze_memory on a read-only port.
- Used as the self-check for solver output in system-level runs and on silicon debug.

Parameters:
ADDR_W, 4, X coordinate width
ADDR_H, 4, Y coordinate width
WIDTH, 16, maze columns; goal X = WIDTH-1
HEIGHT, 16, maze rows; goal Y = HEIGHT-1
STEP_W, 8, step counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  pulse: clear state and begin a new check at (0,0)
move_valid  input  1  move present on move
move  input  2  direction: 00 = Y-1, 01 = X+1, 10 = Y+1, 11 = X-1
move_ready  output  1  checker accepts a move this cycle
path_end  input  1  pulse: solver finished (driven from Done)
mem_rd  output  1  memory read strobe
addr_x  output  ADDR_W  memory X address
addr_y  output  ADDR_H  memory Y address
mem_data  input  1  cell value, valid the cycle after mem_rd; 1 = wall, 0 = free
busy  output  1  check in progress
path_ok  output  1  path legal and ended on the goal
path_bad  output  1  path illegal
err_code  output  2  00 none, 01 out of bounds, 10 wall hit, 11 ended off goal
pos_x  output  ADDR_W  current X
pos_y  output  ADDR_H  current Y
step_count  output  STEP_W  accepted legal moves, saturating

Behaviour:
- Reset (async) drives the following:
  - State IDLE.
  - All outputs 0: move_ready, mem_rd, busy, path_ok, path_bad.
  - err_code = 00.
  - Position registers (0,0).
  - step_count = 0.
- States are IDLE, WAIT, READ, EVAL, PASS, FAIL.
- start, sampled in any state including mid-check, takes priority over every other input:
  - Next cycle: state WAIT, position (0,0), step_count 0, path_ok/path_bad/err_code cleared.
  - Any in-flight read result is discarded.
- IDLE: busy = 0. move_valid and path_end are ignored.
- WAIT: busy = 1 and move_ready = 1.
  - A handshake occurs when move_valid & move_ready.
  - On a handshake, the candidate is computed in ADDR+1 bits, signed. X-1 at X = 0, or Y-1 at Y = 0, goes out of bounds. X+1 at WIDTH-1, or Y+1 at HEIGHT-1, also goes out of bounds.
  - Out of bounds: next state FAIL, err_code 01, no memory read.
  - In bounds: the candidate is registered and the next state is READ.
  - path_end in WAIT with no handshake: position == (WIDTH-1, HEIGHT-1) goes to PASS, otherwise FAIL with err_code 11.
  - If path_end and a handshake occur in the same cycle, the move is processed and path_end is lost. The solver must not do this; the bench checks that the move still takes effect.
- READ (1 cycle): mem_rd = 1, addr = candidate, move_ready = 0.
- EVAL (1 cycle):
  - addr holds the candidate; mem_data is sampled.
  - mem_data = 1: FAIL, err_code 10, position unchanged.
  - mem_data = 0: position <= candidate; step_count++ (saturates at 2^STEP_W-1, no wrap); back to WAIT.
- Timing:
  - Handshake at cycle T, mem_rd at T+1, position update at the T+2 edge.
  - move_ready is high again at T+3, so peak throughput is one move per 3 cycles.
- Outside READ/EVAL, addr_x/addr_y = current position and mem_rd = 0.
- PASS: path_ok = 1, busy = 0. Held until start or rst; moves and path_end are ignored.
- FAIL: path_bad = 1, busy = 0, err_code held. Held until start or rst; moves and path_end are ignored.
- path_ok and path_bad are never 1 simultaneously.
- The start cell (0,0) is not read; it is free by maze convention.
- There is no check for revisiting a cell; loops are legal.

Test Plan:
1. Open 16x16 map, start. Send 15x 01 then 15x 10, then path_end -> path_ok=1, err_code=00, pos=(15,15), step_count=30.
2. Handshake cadence, continuous move_valid -> move_ready high at T, T+3, T+6; mem_rd one cycle at T+1 with addr = the candidate.
3. From (0,0), move 00 -> path_bad=1 and err_code=01 two cycles after the handshake; mem_rd never asserted.
4. Wall at (1,0), move 01 -> mem_rd at addr (1,0), path_bad=1, err_code=10, pos stays (0,0), step_count=0.
5. Moves 01,10 then path_end -> path_bad=1, err_code=11, pos=(1,1); further moves are not accepted (move_ready=0).
6. Issue start during READ, and separately assert rst mid-check -> state cleared, pos=(0,0), flags 0, no position update from the stale read; after start a new check runs correctly.
